// File: rtl/cordic_arb_pkg.sv
// Shared definitions for the CORDIC magnitude engine arbiter.
// Holds default widths and latency, the in-flight tag type and the
// round-robin search helper used by cordic_sqrt_arbiter.
package cordic_arb_pkg;

    localparam int DATA_WIDTH_DEF  = 18;
    localparam int ENG_LATENCY_DEF = 13;

    // Tag index is sized for the largest supported requester count so the
    // type can live here, independent of the instance's NUM_REQ.
    localparam int MAX_REQ = 8;
    localparam int TAG_IW  = $clog2(MAX_REQ);

    typedef struct packed {
        logic              vld;
        logic [TAG_IW-1:0] idx;
    } tag_t;

    typedef struct packed {
        logic              found;
        logic [TAG_IW-1:0] idx;
    } rr_pick_t;

    // Search from last+1 with modulo-num_req wrap; first eligible wins.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] elig,
                                         input logic [TAG_IW-1:0]  last,
                                         input int                 num_req);
        rr_pick_t          res;
        int                cand;
        logic [TAG_IW-1:0] cand_idx;
        res = '0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            cand     = (int'(last) + k) % num_req;
            cand_idx = cand[TAG_IW-1:0];
            if (k <= num_req && !res.found && elig[cand_idx]) begin
                res.found = 1'b1;
                res.idx   = cand_idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/cordic_arb_resp_fifo.sv
// Per-requester first-word-fall-through response FIFO.
// Latency: a push is visible at the head the cycle after the write edge.
// Backpressure: head is held until pop_rdy; pops of an empty FIFO are ignored.
// Ports: clk/rst, push_vld/push_dat (write), pop_rdy (consume head),
//        head_vld/head_dat (FWFT head, data forced to 0 when empty),
//        count (current occupancy, used for credit accounting upstream).
module cordic_arb_resp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 18
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_vld,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop_rdy,
    output logic                       head_vld,
    output logic [WIDTH-1:0]           head_dat,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop  = pop_rdy && (cnt_q != '0);
        // Upstream credit keeps this from ever being full on a push; the
        // guard only protects the array if that contract is broken.
        do_push = push_vld && ((cnt_q != CNT_W'(DEPTH)) || do_pop);
        mem_d   = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
        end
        // DEPTH is a power of two, so natural pointer overflow is the wrap.
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head_vld = (cnt_q != '0);
    assign head_dat = head_vld ? mem_q[rd_ptr_q] : '0;
    assign count    = cnt_q;

endmodule

// File: rtl/cordic_sqrt_arbiter.sv
// Round-robin sequencer sharing one pipelined CORDIC magnitude engine.
// Latency: accept edge E -> eng_start in cycle E..E+1 -> FIFO write at E+1+ENG_LATENCY.
// Backpressure: a requester is granted only while inflight+count < RESP_DEPTH.
// Ports: req_valid/req_ready/req_x/req_y (packed per-requester operands),
//        resp_valid/resp_ready/resp_data (per-requester FWFT results),
//        eng_start/eng_x/eng_y (registered engine issue), eng_result (engine output).
// Optional macro CORDIC_ARB_PERF_EN adds perf_issue_cnt and perf_stall_cnt.
module cordic_sqrt_arbiter
    import cordic_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int ENG_LATENCY = ENG_LATENCY_DEF,
    parameter int RESP_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_x,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_y,
    output logic [NUM_REQ-1:0]            resp_valid,
    input  logic [NUM_REQ-1:0]            resp_ready,
    output logic [NUM_REQ*DATA_WIDTH-1:0] resp_data,
    output logic                          eng_start,
    output logic [DATA_WIDTH-1:0]         eng_x,
    output logic [DATA_WIDTH-1:0]         eng_y,
`ifdef CORDIC_ARB_PERF_EN
    output logic [31:0]                   perf_issue_cnt,
    output logic [31:0]                   perf_stall_cnt,
`endif
    input  logic [DATA_WIDTH-1:0]         eng_result
);

    localparam int CNT_W = $clog2(RESP_DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;

    logic [MAX_REQ-1:0]    elig;
    rr_pick_t              pick;
    logic                  xfer;
    logic [NUM_REQ-1:0]    issue;
    logic [NUM_REQ-1:0]    retire;
    logic [DATA_WIDTH-1:0] sel_x, sel_y;
    logic [CNT_W-1:0]      resp_cnt [NUM_REQ];
    tag_t                  ret_tag;

    logic [TAG_IW-1:0]     last_grant_q, last_grant_d;
    logic                  eng_start_q, eng_start_d;
    logic [TAG_IW-1:0]     eng_idx_q, eng_idx_d;
    logic [DATA_WIDTH-1:0] eng_x_q, eng_x_d;
    logic [DATA_WIDTH-1:0] eng_y_q, eng_y_d;
    logic [CNT_W-1:0]      inflight_q [NUM_REQ];
    logic [CNT_W-1:0]      inflight_d [NUM_REQ];
    tag_t                  tag_q [ENG_LATENCY];
    tag_t                  tag_d [ENG_LATENCY];

    // Arbitration and operand select.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_valid[i] &&
                      (({1'b0, inflight_q[i]} + {1'b0, resp_cnt[i]}) < SUM_W'(RESP_DEPTH));
        end
        pick = rr_pick(elig, last_grant_q, NUM_REQ);
        // Eligibility already implies req_valid, so a grant is a transfer.
        // Held off during reset so req_ready reads 0 while rst is high.
        xfer      = pick.found && !rst;
        req_ready = '0;
        issue     = '0;
        sel_x     = '0;
        sel_y     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick.idx == TAG_IW'(i)) begin
                req_ready[i] = xfer;
                issue[i]     = xfer;
                sel_x        = req_x[i*DATA_WIDTH +: DATA_WIDTH];
                sel_y        = req_y[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Engine issue registers and tag pipe.
    always_comb begin
        last_grant_d = xfer ? pick.idx : last_grant_q;
        eng_start_d  = xfer;
        eng_idx_d    = xfer ? pick.idx : eng_idx_q;
        eng_x_d      = xfer ? sel_x : eng_x_q;
        eng_y_d      = xfer ? sel_y : eng_y_q;
        // Stage 0 takes the tag of the op currently on eng_start, so the
        // last stage lines up with the cycle eng_result carries that op.
        tag_d[0].vld = eng_start_q;
        tag_d[0].idx = eng_idx_q;
        for (int k = 1; k < ENG_LATENCY; k++) begin
            tag_d[k] = tag_q[k-1];
        end
    end

    // Retire steering and credit counters.
    always_comb begin
        ret_tag = tag_q[ENG_LATENCY-1];
        retire  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            retire[i]     = ret_tag.vld && (ret_tag.idx == TAG_IW'(i));
            // Issue and retire on the same edge cancel out.
            inflight_d[i] = inflight_q[i] + CNT_W'(issue[i]) - CNT_W'(retire[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= TAG_IW'(NUM_REQ - 1);
            eng_start_q  <= 1'b0;
            eng_idx_q    <= '0;
            eng_x_q      <= '0;
            eng_y_q      <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                inflight_q[i] <= '0;
            end
            for (int k = 0; k < ENG_LATENCY; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            last_grant_q <= last_grant_d;
            eng_start_q  <= eng_start_d;
            eng_idx_q    <= eng_idx_d;
            eng_x_q      <= eng_x_d;
            eng_y_q      <= eng_y_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                inflight_q[i] <= inflight_d[i];
            end
            for (int k = 0; k < ENG_LATENCY; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

    assign eng_start = eng_start_q;
    assign eng_x     = eng_x_q;
    assign eng_y     = eng_y_q;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_resp
        cordic_arb_resp_fifo #(
            .DEPTH (RESP_DEPTH),
            .WIDTH (DATA_WIDTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push_vld (retire[gi]),
            .push_dat (eng_result),
            .pop_rdy  (resp_ready[gi]),
            .head_vld (resp_valid[gi]),
            .head_dat (resp_data[gi*DATA_WIDTH +: DATA_WIDTH]),
            .count    (resp_cnt[gi])
        );
    end

`ifdef CORDIC_ARB_PERF_EN
    logic [31:0] perf_issue_cnt_q, perf_issue_cnt_d;
    logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;

    always_comb begin
        perf_issue_cnt_d = perf_issue_cnt_q;
        perf_stall_cnt_d = perf_stall_cnt_q;
        if (xfer && (perf_issue_cnt_q != '1)) begin
            perf_issue_cnt_d = perf_issue_cnt_q + 32'd1;
        end
        if ((|req_valid) && !xfer && (perf_stall_cnt_q != '1)) begin
            perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issue_cnt_q <= '0;
            perf_stall_cnt_q <= '0;
        end else begin
            perf_issue_cnt_q <= perf_issue_cnt_d;
            perf_stall_cnt_q <= perf_stall_cnt_d;
        end
    end

    assign perf_issue_cnt = perf_issue_cnt_q;
    assign perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule
